// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the pushbutton/switch input conditioner.
// Imported by the debounce cell and the top level.
package input_conditioner_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } cell_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

    // Width of the stability counter; never narrower than one bit.
    function automatic int counter_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One synchronizer + debouncer for a single asynchronous input bit.
// 'level' is the debounced value; 'toggle' pulses in the cycle it changes.
module debounce_cell
    import input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_SYNC_VAL  = 1'b0,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic raw,
    output logic level,
    output logic toggle
);

    localparam int             CW       = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_val;
    cell_state_e            state;
    cell_state_e            state_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   level_next;
    logic                   toggle_next;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync_ff <= {SYNC_STAGES{RESET_SYNC_VAL}};
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
        end
    end

    // Inversion happens after the synchronizer so everything below is active-high.
    assign sync_val = sync_ff[SYNC_STAGES-1] ^ INVERT;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state  <= IDLE;
            count  <= '0;
            level  <= 1'b0;
            toggle <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            level  <= level_next;
            toggle <= toggle_next;
        end
    end

    // The IDLE cycle that first sees a difference already counts as stable sample one.
    always_comb begin
        state_next  = state;
        count_next  = count;
        level_next  = level;
        toggle_next = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (sync_val != level) begin
                    state_next = COUNT;
                    count_next = CW'(1);
                end
            end
            COUNT: begin
                if (sync_val == level) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == CNT_LAST) begin
                    state_next  = IDLE;
                    count_next  = '0;
                    level_next  = sync_val;
                    toggle_next = 1'b1;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounced key/switch front end feeding the System key and switch PIO inputs.
// Adds press/release pulses and sticky per-key press flags with a clear handshake.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_event,
    input  logic [NUM_KEYS-1:0] key_event_clr,
    output logic [NUM_SW-1:0]   sw_level,
    output logic [NUM_SW-1:0]   sw_change
);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_bad_params
        $error("input_conditioner: DEBOUNCE_CYCLES and SYNC_STAGES must both be >= 2");
    end

    logic [NUM_KEYS-1:0] key_toggle;

    // Key pins idle high, so their synchronizers reset to 1 and are inverted.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_SYNC_VAL  (1'b1),
            .INVERT          (1'b1)
        ) u_cell (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .raw           (key_raw_n[i]),
            .level         (key_level[i]),
            .toggle        (key_toggle[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_SYNC_VAL  (1'b0),
            .INVERT          (1'b0)
        ) u_cell (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .raw           (sw_raw[i]),
            .level         (sw_level[i]),
            .toggle        (sw_change[i])
        );
    end

    assign key_press   = key_toggle & key_level;
    assign key_release = key_toggle & ~key_level;

    // A press arriving together with a clear wins, so no press is ever lost.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            key_event <= '0;
        end else begin
            key_event <= (key_event & ~key_event_clr) | key_press;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random stimulus,
// all compared against a run-length reference model of the debounce rules.
module tb_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 10;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int NB = NK + NS;
    localparam int OW = 4 * NK + 2 * NS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw_n;
    logic [NS-1:0] sw_raw;
    logic [NK-1:0] key_event_clr;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_event;
    logic [NS-1:0] sw_level;
    logic [NS-1:0] sw_change;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .NUM_KEYS        (NK),
        .NUM_SW          (NS),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_raw_n     (key_raw_n),
        .sw_raw        (sw_raw),
        .key_level     (key_level),
        .key_press     (key_press),
        .key_release   (key_release),
        .key_event     (key_event),
        .key_event_clr (key_event_clr),
        .sw_level      (sw_level),
        .sw_change     (sw_change)
    );

    // Reference model: active-high input history, debounced levels and stable-run lengths.
    logic [NB-1:0] m_hist [SS];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_tog;
    logic [NK-1:0] m_event;
    int            m_run [NB];

    task automatic model_edge();
        logic [NB-1:0] cur;
        logic [NB-1:0] synced;
        logic [NK-1:0] press_prev;
        cur = {sw_raw, ~key_raw_n};
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) m_hist[i] = '0;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
            m_level = '0;
            m_tog   = '0;
            m_event = '0;
        end else begin
            press_prev = m_tog[NK-1:0] & m_level[NK-1:0];
            m_event    = (m_event & ~key_event_clr) | press_prev;
            synced     = m_hist[SS-1];
            m_tog      = '0;
            for (int b = 0; b < NB; b++) begin
                if (synced[b] !== m_level[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DC) begin
                        m_level[b] = synced[b];
                        m_tog[b]   = 1'b1;
                        m_run[b]   = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = cur;
        end
    endtask

    function automatic logic [OW-1:0] exp_vec();
        logic [NK-1:0] kl;
        logic [NK-1:0] kt;
        kl = m_level[NK-1:0];
        kt = m_tog[NK-1:0];
        return {kl, kt & kl, kt & ~kl, m_event, m_level[NB-1:NK], m_tog[NB-1:NK]};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {key_level, key_press, key_release, key_event, sw_level, sw_change};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_raw_n = '1;
        sw_raw = '0;
        key_event_clr = '0;
        for (int t = 0; t < 5; t++) begin
            if (t == 3) rst_n = 1'b1;
            tick();
            total++;
            if (obs_vec() !== {OW{1'b0}}) begin
                bad++;
                $display("[TB] FAIL reset_state t=%0d: got %h expected 0", t, obs_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        key_raw_n[0] = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL press_model t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
            if (t < 6) begin
                total++;
                if (key_level[0] !== 1'b0 || key_press[0] !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL press_early t=%0d: level=%b press=%b expected 0 0", t, key_level[0], key_press[0]);
                end
            end else if (t == 6) begin
                total++;
                if (key_level[0] !== 1'b1 || key_press[0] !== 1'b1 || key_event[0] !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL press_edge6: level=%b press=%b event=%b expected 1 1 0", key_level[0], key_press[0], key_event[0]);
                end
            end else begin
                total++;
                if (key_press[0] !== 1'b0 || key_event[0] !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL press_edge7: press=%b event=%b expected 0 1", key_press[0], key_event[0]);
                end
            end
        end
        key_raw_n[0] = 1'b1;
        key_event_clr[0] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL press_settle t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
        key_event_clr[0] = 1'b0;
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 4; t++) begin
            key_raw_n[1] = (t == 3);
            tick();
            total++;
            if (key_press[1] !== 1'b0 || key_level[1] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bounce_quiet t=%0d: press=%b level=%b expected 0 0", t, key_press[1], key_level[1]);
            end
        end
        key_raw_n[1] = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL bounce_model t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
            total++;
            if (key_level[1] !== (t >= 6) || key_press[1] !== (t == 6)) begin
                bad++;
                $display("[TB] FAIL bounce_level t=%0d: level=%b press=%b expected %b %b", t, key_level[1], key_press[1], t >= 6, t == 6);
            end
        end
        key_raw_n[1] = 1'b1;
        for (int t = 0; t < 7; t++) tick();
    endtask

    task automatic test_glitch();
        for (int t = 0; t < 12; t++) begin
            sw_raw[5] = (t < 3);
            tick();
            total++;
            if (sw_level[5] !== 1'b0 || sw_change[5] !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL glitch t=%0d: level=%b change=%b vec=%h expected 0 0 %h", t, sw_level[5], sw_change[5], obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_release_clear();
        int releases;
        releases = 0;
        key_raw_n[2] = 1'b0;
        for (int t = 0; t < 7; t++) tick();
        key_raw_n[2] = 1'b1;
        for (int t = 0; t < 9; t++) begin
            tick();
            if (key_release[2] === 1'b1) releases++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL release_model t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
        total++;
        if (releases != 1) begin
            bad++;
            $display("[TB] FAIL release_count: got %0d expected 1", releases);
        end
        key_event_clr[2] = 1'b1;
        tick();
        key_event_clr[2] = 1'b0;
        total++;
        if (key_event[2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_pending: got %b expected 0", key_event[2]);
        end
        key_raw_n[2] = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        total++;
        if (key_press[2] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL repress_pulse: got %b expected 1", key_press[2]);
        end
        key_event_clr[2] = 1'b1;
        tick();
        total++;
        if (key_event[2] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL set_wins: got %b expected 1", key_event[2]);
        end
        tick();
        total++;
        if (key_event[2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_next: got %b expected 0", key_event[2]);
        end
        key_event_clr[2] = 1'b0;
        key_raw_n[2] = 1'b1;
        for (int t = 0; t < 7; t++) tick();
    endtask

    task automatic test_reset_mid_count();
        key_raw_n[3] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            total++;
            if (key_press[3] !== 1'b0 || key_level[3] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midcount_quiet t=%0d: press=%b level=%b expected 0 0", t, key_press[3], key_level[3]);
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (obs_vec() !== {OW{1'b0}}) begin
            bad++;
            $display("[TB] FAIL midcount_reset: got %h expected 0", obs_vec());
        end
        for (int t = 1; t <= 7; t++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec() || key_level[3] !== (t >= 6) || key_press[3] !== (t == 6)) begin
                bad++;
                $display("[TB] FAIL midcount_relatch t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
        key_raw_n[3] = 1'b1;
        for (int t = 0; t < 7; t++) tick();
    endtask

    task automatic test_switch_powerup();
        key_raw_n = '1;
        sw_raw = '1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL powerup_model t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
            total++;
            if (sw_level !== ((t >= 6) ? 10'h3FF : 10'h000) || sw_change !== ((t == 6) ? 10'h3FF : 10'h000)) begin
                bad++;
                $display("[TB] FAIL powerup t=%0d: level=%h change=%h", t, sw_level, sw_change);
            end
        end
        sw_raw = '0;
        for (int t = 0; t < 7; t++) tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 800; t++) begin
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, 6) == 0) key_raw_n[b] = ~key_raw_n[b];
            for (int b = 0; b < NS; b++)
                if ($urandom_range(0, 6) == 0) sw_raw[b] = ~sw_raw[b];
            key_event_clr = ($urandom_range(0, 3) == 0) ? NK'($urandom) : '0;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL random t=%0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        key_raw_n = '1;
        sw_raw = '0;
        key_event_clr = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_clear();
        test_reset_mid_count();
        test_switch_powerup();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
